sdram_fifo_ctrl: RTL and testbench

Upstream user-side adapter for sdram_ctrl. It buffers a user write stream in a write FIFO and issues fixed-length write bursts to sdram_ctrl at incrementing, wrapping addresses. It also prefetches read bursts into a read FIFO that the user drains. A single clock domain is shared with sdram_ctrl.

---
 rtl/sdram_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdram_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_fifo_ctrl.sv
// User-side adapter for sdram_ctrl: buffers a write stream into fixed-length write bursts and
// prefetches read bursts into a read FIFO, arbitrating round-robin between the two.
module sdram_fifo_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned FIFO_AW    = 10,
    parameter int unsigned WR_BST_LEN = 10,
    parameter int unsigned RD_BST_LEN = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_din,
    output logic              wr_full,
    output logic [FIFO_AW:0]  wr_level,
    input  logic [ADDR_W-1:0] wr_base_addr,
    input  logic [ADDR_W-1:0] wr_end_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_dout,
    output logic              rd_empty,
    output logic [FIFO_AW:0]  rd_level,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_base_addr,
    input  logic [ADDR_W-1:0] rd_end_addr,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [DATA_W-1:0] sdram_wr_data,
    output logic [9:0]        sdram_wr_bst_len,
    input  logic              sdram_wr_ack,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [9:0]        sdram_rd_bst_len,
    input  logic              sdram_rd_ack,
    input  logic [DATA_W-1:0] sdram_rd_data
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned AW2   = ADDR_W + 2;

    localparam logic [LW-1:0]      LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]      DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0]      WR_BST_L = LW'(WR_BST_LEN);
    localparam logic [LW-1:0]      RD_BST_L = LW'(RD_BST_LEN);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [9:0]         CNT_ONE  = 10'd1;
    localparam logic [9:0]         WR_LAST  = 10'(WR_BST_LEN - 1);
    localparam logic [9:0]         RD_LAST  = 10'(RD_BST_LEN - 1);
    localparam logic [AW2-1:0]     WR_LEN_A = AW2'(WR_BST_LEN);
    localparam logic [AW2-1:0]     WR_LM1_A = AW2'(WR_BST_LEN - 1);
    localparam logic [AW2-1:0]     RD_LEN_A = AW2'(RD_BST_LEN);
    localparam logic [AW2-1:0]     RD_LM1_A = AW2'(RD_BST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    // Falls back to base when the next burst would overrun end_addr or the address space.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] last_addr,
                                                    input logic [AW2-1:0]    len,
                                                    input logic [AW2-1:0]    len_m1);
        logic [AW2-1:0] nxt;
        logic [AW2-1:0] tail;
        nxt  = {2'b00, addr} + len;
        tail = nxt + len_m1;
        if (nxt[ADDR_W] || (tail > {2'b00, last_addr})) begin
            next_addr = base;
        end else begin
            next_addr = nxt[ADDR_W-1:0];
        end
    endfunction

    // ---------------- write FIFO ----------------
    logic [DATA_W-1:0]  wf_mem [DEPTH];
    logic [FIFO_AW-1:0] wf_wptr_q, wf_rptr_q;
    logic [LW-1:0]      wf_level_q;
    logic               wf_push, wf_pop, wf_empty;

    assign wf_empty      = (wf_level_q == '0);
    assign wr_full       = (wf_level_q == DEPTH_L);
    assign wr_level      = wf_level_q;
    assign wf_pop        = sdram_wr_ack && !wf_empty;
    assign wf_push       = wr_en && (!wr_full || wf_pop);
    assign sdram_wr_data = wf_empty ? '0 : wf_mem[wf_rptr_q];

    always_ff @(posedge clk) begin
        if (wf_push) begin
            wf_mem[wf_wptr_q] <= wr_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wf_wptr_q  <= '0;
            wf_rptr_q  <= '0;
            wf_level_q <= '0;
        end else begin
            if (wf_push) wf_wptr_q <= wf_wptr_q + PTR_ONE;
            if (wf_pop)  wf_rptr_q <= wf_rptr_q + PTR_ONE;
            if (wf_push && !wf_pop) begin
                wf_level_q <= wf_level_q + LVL_ONE;
            end else if (wf_pop && !wf_push) begin
                wf_level_q <= wf_level_q - LVL_ONE;
            end
        end
    end

    // ---------------- read FIFO ----------------
    logic [DATA_W-1:0]  rf_mem [DEPTH];
    logic [FIFO_AW-1:0] rf_wptr_q, rf_rptr_q;
    logic [LW-1:0]      rf_level_q;
    logic               rf_push, rf_pop, rf_full;

    assign rd_empty = (rf_level_q == '0);
    assign rf_full  = (rf_level_q == DEPTH_L);
    assign rd_level = rf_level_q;
    assign rf_pop   = rd_en && !rd_empty;
    assign rf_push  = sdram_rd_ack && (!rf_full || rf_pop);
    assign rd_dout  = rd_empty ? '0 : rf_mem[rf_rptr_q];

    always_ff @(posedge clk) begin
        if (rf_push) begin
            rf_mem[rf_wptr_q] <= sdram_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wptr_q  <= '0;
            rf_rptr_q  <= '0;
            rf_level_q <= '0;
        end else begin
            if (rf_push) rf_wptr_q <= rf_wptr_q + PTR_ONE;
            if (rf_pop)  rf_rptr_q <= rf_rptr_q + PTR_ONE;
            if (rf_push && !rf_pop) begin
                rf_level_q <= rf_level_q + LVL_ONE;
            end else if (rf_pop && !rf_push) begin
                rf_level_q <= rf_level_q - LVL_ONE;
            end
        end
    end

    // ---------------- burst arbiter ----------------
    state_e            state_q, state_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              loaded_q;
    logic              rd_valid_q;
    logic              wr_go, rd_go;

    assign wr_go = init_end && (wf_level_q >= WR_BST_L);
    assign rd_go = init_end && rd_valid && ((DEPTH_L - rf_level_q) >= RD_BST_L);

    assign sdram_wr_req     = wr_req_q;
    assign sdram_rd_req     = rd_req_q;
    assign sdram_wr_addr    = wr_addr_q;
    assign sdram_rd_addr    = rd_addr_q;
    assign sdram_wr_bst_len = 10'(WR_BST_LEN);
    assign sdram_rd_bst_len = 10'(RD_BST_LEN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        last_wr_d = last_wr_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;

        if (!loaded_q) begin
            wr_addr_d = wr_base_addr;
            rd_addr_d = rd_base_addr;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (wr_go && (!rd_go || !last_wr_q)) begin
                    state_d = StWr;
                end else if (rd_go) begin
                    state_d = StRd;
                end
            end
            StWr: begin
                wr_req_d = 1'b1;
                if (sdram_wr_ack) begin
                    if (cnt_q == WR_LAST) begin
                        state_d   = StIdle;
                        wr_req_d  = 1'b0;
                        cnt_d     = '0;
                        last_wr_d = 1'b1;
                        wr_addr_d = next_addr(wr_addr_q, wr_base_addr, wr_end_addr,
                                              WR_LEN_A, WR_LM1_A);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            StRd: begin
                rd_req_d = 1'b1;
                if (sdram_rd_ack) begin
                    if (cnt_q == RD_LAST) begin
                        state_d   = StIdle;
                        rd_req_d  = 1'b0;
                        cnt_d     = '0;
                        last_wr_d = 1'b0;
                        rd_addr_d = next_addr(rd_addr_q, rd_base_addr, rd_end_addr,
                                              RD_LEN_A, RD_LM1_A);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Re-enabling prefetch restarts the read region; buffered data stays.
        if (rd_valid && !rd_valid_q) begin
            rd_addr_d = rd_base_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            last_wr_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            loaded_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            last_wr_q  <= last_wr_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            loaded_q   <= 1'b1;
            rd_valid_q <= rd_valid;
        end
    end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Directed self-checking bench for sdram_fifo_ctrl; the bench itself plays the sdram_ctrl side.
module tb_sdram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        init_end;
    logic        wr_en;
    logic [15:0] wr_din;
    logic        wr_full;
    logic [10:0] wr_level;
    logic [23:0] wr_base_addr, wr_end_addr;
    logic        rd_en;
    logic [15:0] rd_dout;
    logic        rd_empty;
    logic [10:0] rd_level;
    logic        rd_valid;
    logic [23:0] rd_base_addr, rd_end_addr;
    logic        sdram_wr_req;
    logic [23:0] sdram_wr_addr;
    logic [15:0] sdram_wr_data;
    logic [9:0]  sdram_wr_bst_len;
    logic        sdram_wr_ack;
    logic        sdram_rd_req;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_bst_len;
    logic        sdram_rd_ack;
    logic [15:0] sdram_rd_data;

    int n_checks = 0;
    int n_bad    = 0;
    int rd_word  = 0;

    sdram_fifo_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_end         (init_end),
        .wr_en            (wr_en),
        .wr_din           (wr_din),
        .wr_full          (wr_full),
        .wr_level         (wr_level),
        .wr_base_addr     (wr_base_addr),
        .wr_end_addr      (wr_end_addr),
        .rd_en            (rd_en),
        .rd_dout          (rd_dout),
        .rd_empty         (rd_empty),
        .rd_level         (rd_level),
        .rd_valid         (rd_valid),
        .rd_base_addr     (rd_base_addr),
        .rd_end_addr      (rd_end_addr),
        .sdram_wr_req     (sdram_wr_req),
        .sdram_wr_addr    (sdram_wr_addr),
        .sdram_wr_data    (sdram_wr_data),
        .sdram_wr_bst_len (sdram_wr_bst_len),
        .sdram_wr_ack     (sdram_wr_ack),
        .sdram_rd_req     (sdram_rd_req),
        .sdram_rd_addr    (sdram_rd_addr),
        .sdram_rd_bst_len (sdram_rd_bst_len),
        .sdram_rd_ack     (sdram_rd_ack),
        .sdram_rd_data    (sdram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en  = 1'b1;
            wr_din = 16'(first + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_req(input logic want_wr);
        int n = 0;
        while (!sdram_wr_req && !sdram_rd_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_seen", 32'(sdram_wr_req | sdram_rd_req), 32'd1);
        check_eq("grant_is_wr", 32'(sdram_wr_req), 32'(want_wr));
    endtask

    task automatic wr_burst(input logic [23:0] exp_addr, input int first);
        wait_req(1'b1);
        for (int i = 0; i < 10; i++) begin
            check_eq("wr_addr", 32'(sdram_wr_addr), 32'(exp_addr));
            check_eq("wr_data", 32'(sdram_wr_data), 32'(16'(first + i)));
            sdram_wr_ack = 1'b1;
            @(negedge clk);
        end
        sdram_wr_ack = 1'b0;
        check_eq("wr_req_drop", 32'(sdram_wr_req), 32'd0);
    endtask

    task automatic rd_burst(input logic [23:0] exp_addr);
        wait_req(1'b0);
        for (int i = 0; i < 10; i++) begin
            check_eq("rd_addr", 32'(sdram_rd_addr), 32'(exp_addr));
            sdram_rd_data = 16'(rd_word);
            rd_word++;
            sdram_rd_ack = 1'b1;
            @(negedge clk);
        end
        sdram_rd_ack = 1'b0;
        check_eq("rd_req_drop", 32'(sdram_rd_req), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        init_end      = 1'b0;
        wr_en         = 1'b0;
        wr_din        = '0;
        rd_en         = 1'b0;
        rd_valid      = 1'b0;
        wr_base_addr  = 24'h000000;
        wr_end_addr   = 24'hFFFFFF;
        rd_base_addr  = 24'h000000;
        rd_end_addr   = 24'hFFFFFF;
        sdram_wr_ack  = 1'b0;
        sdram_rd_ack  = 1'b0;
        sdram_rd_data = '0;
        idle(2);

        // Reset values
        check_eq("rst_wr_full", 32'(wr_full), 32'd0);
        check_eq("rst_rd_empty", 32'(rd_empty), 32'd1);
        check_eq("rst_wr_level", 32'(wr_level), 32'd0);
        check_eq("rst_rd_level", 32'(rd_level), 32'd0);
        check_eq("rst_rd_dout", 32'(rd_dout), 32'd0);
        check_eq("rst_wr_req", 32'(sdram_wr_req), 32'd0);
        check_eq("rst_rd_req", 32'(sdram_rd_req), 32'd0);
        check_eq("rst_wr_data", 32'(sdram_wr_data), 32'd0);
        check_eq("wr_bst_len", 32'(sdram_wr_bst_len), 32'd10);
        check_eq("rd_bst_len", 32'(sdram_rd_bst_len), 32'd10);
        rst_n = 1'b1;
        idle(1);

        // 1: one full burst at address 0
        init_end = 1'b1;
        push_words(0, 10);
        wr_burst(24'h000000, 0);
        check_eq("t1_wr_level", 32'(wr_level), 32'd0);

        // 2: nine words do not trigger; the tenth does, two cycles later
        push_words(100, 9);
        idle(10);
        check_eq("t2_no_req", 32'(sdram_wr_req), 32'd0);
        check_eq("t2_level9", 32'(wr_level), 32'd9);
        wr_en  = 1'b1;
        wr_din = 16'd109;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("t2_req_c1", 32'(sdram_wr_req), 32'd0);
        check_eq("t2_level10", 32'(wr_level), 32'd10);
        @(negedge clk);
        check_eq("t2_req_c2", 32'(sdram_wr_req), 32'd0);
        @(negedge clk);
        check_eq("t2_req_c3", 32'(sdram_wr_req), 32'd1);
        wr_burst(24'h00000A, 100);
        init_end = 1'b0;
        push_words(200, 10);
        idle(30);
        check_eq("t2_held_off", 32'(sdram_wr_req), 32'd0);
        check_eq("t2_held_level", 32'(wr_level), 32'd10);
        init_end = 1'b1;
        wr_burst(24'h000014, 200);

        // 3: small write region wraps back to base
        wr_base_addr = 24'h000100;
        wr_end_addr  = 24'h000113;
        init_end     = 1'b0;
        do_reset();
        push_words(300, 30);
        check_eq("t3_level30", 32'(wr_level), 32'd30);
        init_end = 1'b1;
        wr_burst(24'h000100, 300);
        wr_burst(24'h00010A, 310);
        wr_burst(24'h000100, 320);
        check_eq("t3_level0", 32'(wr_level), 32'd0);

        // 4: read prefetch fills until fewer than 10 free slots remain
        rd_word  = 0;
        rd_valid = 1'b1;
        for (int k = 0; k < 102; k++) begin
            rd_burst(24'(k * 10));
        end
        idle(30);
        check_eq("t4_no_more_rd", 32'(sdram_rd_req), 32'd0);
        check_eq("t4_rd_level", 32'(rd_level), 32'd1020);
        rd_valid = 1'b0;
        for (int i = 0; i < 1020; i++) begin
            check_eq("t4_rd_dout", 32'(rd_dout), 32'(16'(i)));
            rd_en = 1'b1;
            @(negedge clk);
        end
        rd_en = 1'b0;
        check_eq("t4_rd_empty", 32'(rd_empty), 32'd1);
        check_eq("t4_rd_level0", 32'(rd_level), 32'd0);
        check_eq("t4_rd_dout0", 32'(rd_dout), 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_eq("t4_pop_empty", 32'(rd_level), 32'd0);

        // 5: round robin, rd_valid fall blocks reads, rise reloads the read pointer
        wr_base_addr = 24'h000000;
        wr_end_addr  = 24'hFFFFFF;
        rd_base_addr = 24'h001000;
        init_end     = 1'b0;
        do_reset();
        push_words(500, 20);
        rd_valid = 1'b1;
        init_end = 1'b1;
        wr_burst(24'h000000, 500);
        rd_burst(24'h001000);
        rd_valid = 1'b0;
        wr_burst(24'h00000A, 510);
        check_eq("t5_rd_level", 32'(rd_level), 32'd10);
        rd_valid = 1'b1;
        rd_burst(24'h001000);
        check_eq("t5_rd_level2", 32'(rd_level), 32'd20);

        // 6: fill to full with no acks, drop extras, then reset mid-burst
        rd_valid = 1'b0;
        do_reset();
        push_words(0, 1030);
        check_eq("t6_full", 32'(wr_full), 32'd1);
        check_eq("t6_level", 32'(wr_level), 32'd1024);
        check_eq("t6_req", 32'(sdram_wr_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("t6_wr_data", 32'(sdram_wr_data), 32'(i));
            sdram_wr_ack = 1'b1;
            @(negedge clk);
        end
        sdram_wr_ack = 1'b0;
        check_eq("t6_level_after", 32'(wr_level), 32'd1021);
        check_eq("t6_not_full", 32'(wr_full), 32'd0);
        check_eq("t6_head", 32'(sdram_wr_data), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req", 32'(sdram_wr_req), 32'd0);
        check_eq("t6_rst_level", 32'(wr_level), 32'd0);
        check_eq("t6_rst_data", 32'(sdram_wr_data), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
